// File: rtl/dct_pkg.sv
// Shared constants, FSM state type and zigzag scan table for the DCT
// coefficient reader. The zigzag table is only consumed when the build
// defines DCT_ZIGZAG_EN (see dct_coeff_reader.sv).
package dct_pkg;

  localparam int DCT_DATA_W = 16;
  localparam int DCT_ADDR_W = 6;
  localparam int DCT_N      = 8;
  localparam int DCT_FIFO_D = 4;
  localparam int DCT_NCOEF  = DCT_N * DCT_N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } dct_state_e;

  // JPEG zigzag scan: stream position -> raster RAM address.
  localparam logic [DCT_ADDR_W-1:0] ZZ_LUT [DCT_NCOEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/dct_coeff_reader_if.sv
// Coefficient output stream: valid/ready beat carrying data, stream index
// and last flag. The reader drives it through the master modport, the
// downstream sink through the slave modport.
interface dct_coeff_reader_if
  import dct_pkg::*;
#(
  parameter int DATA_W = DCT_DATA_W,
  parameter int ADDR_W = DCT_ADDR_W
);

  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/dct_coeff_reader_chk.sv
// Runtime checker for the reader's output FIFO: a RAM return must never
// land in a full FIFO (the read-credit logic is meant to prevent it).
module dct_coeff_reader_chk #(
  parameter int CNT_W  = 3,
  parameter int FIFO_D = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic [CNT_W-1:0] count
);

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && (count == CNT_W'(FIFO_D)))
  );

endmodule

// File: rtl/dct_zigzag_rom.sv
// Combinational zigzag scan ROM: stream position -> raster RAM address.
module dct_zigzag_rom
  import dct_pkg::*;
(
  input  logic [DCT_ADDR_W-1:0] idx,
  output logic [DCT_ADDR_W-1:0] addr
);

  // Table lookup of the zigzag order
  always_comb begin
    addr = ZZ_LUT[idx];
  end

endmodule

// File: rtl/dct_coeff_reader.sv
// dct_coeff_reader: drains one 8x8 block of DCT coefficients from the result
// RAM and streams it out as valid/ready beats, one coefficient per beat.
// Build option: define DCT_ZIGZAG_EN for JPEG zigzag read order; otherwise
// the block is read in raster order and the zigzag ROM is not built.
// Reads are issued only when the small output FIFO has room for every read
// already in flight, so the FIFO cannot overflow under any backpressure.
module dct_coeff_reader
  import dct_pkg::*;
#(
  parameter int DATA_W = DCT_DATA_W,
  parameter int ADDR_W = DCT_ADDR_W,
  parameter int FIFO_D = DCT_FIFO_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 ram_cs,
  output logic                 ram_rd,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [DATA_W-1:0]    ram_data,
  output logic                 busy,
  output logic                 done,
  dct_coeff_reader_if.master   out_if
);

  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DCT_NCOEF - 1);
  localparam logic [CNT_W:0]    FIFO_LIM = (CNT_W + 1)'(FIFO_D);

  dct_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] tx_cnt_q, tx_cnt_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_rd_q, ram_rd_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              rdv_q, rdv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fifo_mem_q [FIFO_D];
  logic [DATA_W-1:0] fifo_mem_d [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic [ADDR_W-1:0] order_addr_s;
  logic [CNT_W:0]    inflight_s;
  logic              credit_ok_s;
  logic              push_s;
  logic              pop_s;

`ifdef DCT_ZIGZAG_EN
  dct_zigzag_rom u_zz_rom (
    .idx  (rd_cnt_q),
    .addr (order_addr_s)
  );
`else
  assign order_addr_s = rd_cnt_q;
`endif

  // Handshake, FIFO occupancy and read credit
  always_comb begin
    push_s      = rdv_q;
    pop_s       = valid_q & out_if.out_ready;
    inflight_s  = {1'b0, count_q}
                + {{CNT_W{1'b0}}, rdv_q}
                + {{CNT_W{1'b0}}, ram_rd_q};
    credit_ok_s = (inflight_s < FIFO_LIM);
  end

  // Control FSM next state, read issue and transfer counting
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    ram_rd_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_READ;
          ram_rd_d   = 1'b1;
          ram_addr_d = order_addr_s;
          rd_cnt_d   = rd_cnt_q + ADDR_W'(1);
        end else begin
          rd_cnt_d = '0;
          tx_cnt_d = '0;
        end
      end
      ST_READ: begin
        if (credit_ok_s) begin
          ram_rd_d   = 1'b1;
          ram_addr_d = order_addr_s;
          if (rd_cnt_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + ADDR_W'(1);
          end
        end else begin
          ram_rd_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (pop_s && (tx_cnt_q == LAST_IDX)) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FIN: begin
        state_d  = ST_IDLE;
        rd_cnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (pop_s) begin
      tx_cnt_d = tx_cnt_q + ADDR_W'(1);
    end else begin
      tx_cnt_d = tx_cnt_d;
    end
    rdv_d    = ram_rd_q;
    busy_d   = (state_d != ST_IDLE);
    ram_cs_d = busy_d;
    done_d   = (state_d == ST_FIN);
  end

  // Output FIFO: RAM return pushed the cycle after the read, head popped on handshake
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = ram_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    last_d  = valid_d && (tx_cnt_d == LAST_IDX);
  end

  // State, counter, FIFO and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      ram_cs_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      rdv_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < FIFO_D; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      ram_cs_q   <= ram_cs_d;
      ram_rd_q   <= ram_rd_d;
      ram_addr_q <= ram_addr_d;
      rdv_q      <= rdv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign ram_cs           = ram_cs_q;
  assign ram_rd           = ram_rd_q;
  assign ram_addr         = ram_addr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_data  = fifo_mem_q[rd_ptr_q];
  assign out_if.out_idx   = tx_cnt_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;

  dct_coeff_reader_chk #(
    .CNT_W  (CNT_W),
    .FIFO_D (FIFO_D)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .count (count_q)
  );

endmodule
